// File: rtl/magma_seq_pkg.sv
// magma_seq_pkg: shared constants for the Magma CTR sequencer.
//   State encodings (IDLE/START/WAIT/OUT), default block/key/IV widths and
//   the default watchdog limit used when MAGMA_SEQ_TIMEOUT_EN is defined.
package magma_seq_pkg;
  localparam int BLOCK_W     = 64;
  localparam int KEY_W       = 256;
  localparam int IV_W        = 32;
  localparam int TIMEOUT_CYC = 1024;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;
endpackage

// File: rtl/magma_seq_watchdog.sv
// magma_seq_watchdog: cycle counter that flags a core that never answers.
//   clk, reset : clock, synchronous active-high reset
//   run        : high while the sequencer waits on the core
//   clear      : restart the count
//   expired    : high in the TIMEOUT_CYC-th consecutive run cycle
// Only instantiated when MAGMA_SEQ_TIMEOUT_EN is defined.
module magma_seq_watchdog #(
  parameter int TIMEOUT_CYC = magma_seq_pkg::TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (run)       cnt <= cnt + 16'd1;
  end

  // cnt is 0 in the first run cycle, so LIMIT marks the last allowed one
  assign expired = run && (cnt == LIMIT);
endmodule

// File: rtl/magma_ctr_sequencer.sv
// magma_ctr_sequencer: counter-mode (gamma) sequencer for one magma core.
//   Accepts input blocks over in_valid/in_ready, presents counter {iv,0..}
//   to the core, pulses core_start once per block, waits for core_done and
//   returns in_data ^ keystream over out_valid/out_ready.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   key, iv, iv_load    : new-message load (sampled in IDLE only)
//   in_valid/ready/data : input block handshake
//   out_valid/ready/data: result block handshake
//   core_start, core_data_in, core_key, core_data_out, core_done : core side
//   busy, blk_cnt, err  : status (blk_cnt saturates, err is sticky)
// Optional: define MAGMA_SEQ_TIMEOUT_EN to add the WAIT watchdog and err.
module magma_ctr_sequencer #(
  parameter int BLOCK_W     = magma_seq_pkg::BLOCK_W,
  parameter int KEY_W       = magma_seq_pkg::KEY_W,
  parameter int IV_W        = magma_seq_pkg::IV_W,
  parameter int TIMEOUT_CYC = magma_seq_pkg::TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEY_W-1:0]   key,
  input  logic [IV_W-1:0]    iv,
  input  logic               iv_load,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_data_in,
  output logic [KEY_W-1:0]   core_key,
  input  logic [BLOCK_W-1:0] core_data_out,
  input  logic               core_done,
  output logic               busy,
  output logic [15:0]        blk_cnt,
  output logic               err
);
  import magma_seq_pkg::*;

  state_t             state;
  logic [BLOCK_W-1:0] ctr, din_r, out_r;
  logic [KEY_W-1:0]   key_r;
  logic               wd_expired;

  // iv_load steals the IDLE cycle; reset holds ready low in its own cycle
  assign in_ready     = (state == ST_IDLE) && !reset && !iv_load;
  assign out_valid    = (state == ST_OUT);
  assign core_start   = (state == ST_START);
  assign busy         = (state != ST_IDLE);
  assign out_data     = out_r;
  assign core_data_in = ctr;
  assign core_key     = key_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      ctr     <= '0;
      key_r   <= '0;
      din_r   <= '0;
      out_r   <= '0;
      blk_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iv_load) begin
            key_r   <= key;
            ctr     <= {iv, {(BLOCK_W-IV_W){1'b0}}};
            blk_cnt <= '0;
          end else if (in_valid) begin
            din_r <= in_data;
            state <= ST_START;
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          if (core_done) begin
            out_r <= din_r ^ core_data_out;
            state <= ST_OUT;
          end else if (wd_expired) begin
            // block dropped, counter kept so the message can be retried
            state <= ST_IDLE;
          end
        end
        default: begin
          if (out_ready) begin
            ctr   <= ctr + BLOCK_W'(1);
            if (blk_cnt != 16'hFFFF) blk_cnt <= blk_cnt + 16'd1;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef MAGMA_SEQ_TIMEOUT_EN
  magma_seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk    (clk),
    .reset  (reset),
    .run    (state == ST_WAIT),
    .clear  (state != ST_WAIT),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset)                                             err <= 1'b0;
    else if (state == ST_IDLE && iv_load)                  err <= 1'b0;
    else if (state == ST_WAIT && !core_done && wd_expired) err <= 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC[15:0];
  assign wd_expired     = 1'b0;
  assign err            = 1'b0;
`endif
endmodule

// File: tb/tb_magma_ctr_sequencer.sv
module tb_magma_ctr_sequencer;
  localparam int L = 32;
`ifdef MAGMA_SEQ_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 1024;
`endif
  localparam logic [63:0] PAD = 64'hA5A5_A5A5_A5A5_A5A5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] key = '0;
  logic [31:0]  iv = '0;
  logic         iv_load = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [63:0]  out_data;
  logic         core_start;
  logic [63:0]  core_data_in;
  logic [255:0] core_key;
  logic [63:0]  core_data_out;
  logic         core_done;
  logic         busy;
  logic [15:0]  blk_cnt;
  logic         err;

  magma_ctr_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .key(key), .iv(iv), .iv_load(iv_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_start(core_start), .core_data_in(core_data_in), .core_key(core_key),
    .core_data_out(core_data_out), .core_done(core_done),
    .busy(busy), .blk_cnt(blk_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int cyc_n = 0, starts_n = 0, ovalid_n = 0;
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (core_start) starts_n <= starts_n + 1;
    if (out_valid)  ovalid_n <= ovalid_n + 1;
  end

  // stub core: done L cycles after start, keystream = counter ^ PAD
  logic        stub_en = 1'b1;
  int          rem = 0;
  logic [63:0] ks = '0;
  always @(posedge clk) begin
    if (core_start && stub_en) begin
      rem <= L;
      ks  <= core_data_in ^ PAD;
    end else if (rem > 0) rem <= rem - 1;
  end
  assign core_done     = (rem == 1);
  assign core_data_out = ks;

  int n_chk = 0, n_err = 0;
  int t_acc = 0;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [255:0] k, input logic [31:0] v);
    key = k; iv = v; iv_load = 1'b1;
    cyc();
    iv_load = 1'b0;
  endtask

  // accept one block, return latency to out_valid, start seen, counter seen
  task automatic send(input logic [63:0] d, output int lat, output logic st,
                      output logic [63:0] cd);
    int g = 0;
    while (!in_ready && g < 100) begin cyc(); g++; end
    t_acc = cyc_n;
    in_valid = 1'b1; in_data = d;
    cyc();
    in_valid = 1'b0;
    st = core_start; cd = core_data_in;
    lat = 1;
    while (!out_valid && lat < 200) begin cyc(); lat++; end
  endtask

  typedef struct {
    logic [255:0] k;
    logic [31:0]  v;
    logic [63:0]  din;
    logic [63:0]  exp_ctr;
    logic [63:0]  exp_out;
  } vec_t;
  vec_t vt[3];

  initial begin
    int lat, prev, s0, o0, k;
    logic st;
    logic [63:0] cd, held;

    vt[0] = '{256'h1, 32'h1234_5678, 64'h0,
              64'h1234_5678_0000_0000, 64'hB791_F3DD_A5A5_A5A5};
    vt[1] = '{{8{32'hCAFE_BABE}}, 32'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hDEAD_BEEF_0000_0000, 64'h84F7_E4B5_5A5A_5A5A};
    vt[2] = '{{4{64'h0123_4567_89AB_CDEF}}, 32'h0, 64'h0123_4567_89AB_CDEF,
              64'h0, 64'hA486_E0C2_2C0E_684A};

    // reset state
    cyc();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ctr", core_data_in, 64'd0);
    chk("rst_key", 64'(core_key == 256'd0), 64'd1);
    chk("rst_out_data", out_data, 64'd0);
    reset = 1'b0;
    cyc();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // table-driven single blocks
    for (int i = 0; i < 3; i++) begin
      load(vt[i].k, vt[i].v);
      send(vt[i].din, lat, st, cd);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(L + 2));
      chk($sformatf("v%0d_start", i), 64'(st), 64'd1);
      chk($sformatf("v%0d_ctr", i), cd, vt[i].exp_ctr);
      chk($sformatf("v%0d_key", i), 64'(core_key == vt[i].k), 64'd1);
      chk($sformatf("v%0d_out", i), out_data, vt[i].exp_out);
      cyc();
      chk($sformatf("v%0d_ov_drop", i), 64'(out_valid), 64'd0);
      chk($sformatf("v%0d_blk_cnt", i), 64'(blk_cnt), 64'd1);
      chk($sformatf("v%0d_ctr_next", i), core_data_in, vt[i].exp_ctr + 64'd1);
    end

    // counter advance, back to back
    load(256'h5, 32'h1234_5678);
    s0 = starts_n;
    prev = 0;
    for (int n = 0; n < 3; n++) begin
      send(64'h0, lat, st, cd);
      chk($sformatf("adv%0d_ctr", n), cd, 64'h1234_5678_0000_0000 + 64'(n));
      chk($sformatf("adv%0d_out", n), out_data, cd ^ PAD);
      if (n > 0) chk($sformatf("adv%0d_period", n), 64'(t_acc - prev), 64'(L + 3));
      prev = t_acc;
      cyc();
    end
    chk("adv_blk_cnt", 64'(blk_cnt), 64'd3);
    chk("adv_starts", 64'(starts_n - s0), 64'd3);

    // backpressure
    out_ready = 1'b0;
    s0 = starts_n;
    send(64'hFFFF_0000_FFFF_0000, lat, st, cd);
    chk("bp_ctr", cd, 64'h1234_5678_0000_0003);
    held = out_data;
    chk("bp_out", held, 64'h1234_5678_0000_0003 ^ PAD ^ 64'hFFFF_0000_FFFF_0000);
    for (int j = 0; j < 10; j++) begin
      cyc();
      chk("bp_hold_data", out_data, held);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    chk("bp_one_start", 64'(starts_n - s0), 64'd1);
    out_ready = 1'b1;
    cyc();
    chk("bp_release", 64'(out_valid), 64'd0);
    chk("bp_blk_cnt", 64'(blk_cnt), 64'd4);

    // priority: iv_load beats in_valid in IDLE
    s0 = starts_n;
    key = 256'h77; iv = 32'h55AA_55AA; iv_load = 1'b1;
    in_valid = 1'b1; in_data = 64'h1;
    #1;
    chk("pri_in_ready", 64'(in_ready), 64'd0);
    cyc();
    iv_load = 1'b0; in_valid = 1'b0;
    chk("pri_busy", 64'(busy), 64'd0);
    chk("pri_ctr", core_data_in, 64'h55AA_55AA_0000_0000);
    chk("pri_blk_cnt", 64'(blk_cnt), 64'd0);
    cyc(); cyc();
    chk("pri_no_start", 64'(starts_n - s0), 64'd0);

    // iv_load during WAIT is ignored
    in_valid = 1'b1; in_data = 64'h0;
    cyc();
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    key = 256'h99; iv = 32'h1111_1111; iv_load = 1'b1;
    cyc();
    iv_load = 1'b0;
    k = 0;
    while (!out_valid && k < 200) begin cyc(); k++; end
    chk("wait_ivl_out", out_data, 64'hF00F_F00F_A5A5_A5A5);
    cyc();
    chk("wait_ivl_ctr", core_data_in, 64'h55AA_55AA_0000_0001);
    chk("wait_ivl_key", 64'(core_key == 256'h77), 64'd1);
    chk("wait_ivl_cnt", 64'(blk_cnt), 64'd1);

    // counter wrap
    load(256'h3, 32'hFFFF_FFFF);
    force dut.ctr = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    release dut.ctr;
    cyc();
    send(64'h0, lat, st, cd);
    chk("wrap_ctr", cd, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_out", out_data, 64'h5A5A_5A5A_5A5A_5A5A);
    cyc();
    chk("wrap_next", core_data_in, 64'h0);

    // reset while in WAIT, late core_done ignored
    load(256'hAB, 32'h0F0F_0F0F);
    in_valid = 1'b1; in_data = 64'h3;
    cyc();
    in_valid = 1'b0;
    repeat (10) cyc();
    chk("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    cyc();
    reset = 1'b0;
    o0 = ovalid_n; s0 = starts_n;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ctr", core_data_in, 64'd0);
    chk("mid_rst_key", 64'(core_key == 256'd0), 64'd0 + 64'd1);
    chk("mid_rst_blk", 64'(blk_cnt), 64'd0);
    chk("mid_rst_out", out_data, 64'd0);
    repeat (40) cyc();
    chk("late_done_no_out", 64'(ovalid_n - o0), 64'd0);
    chk("late_done_idle", 64'(busy), 64'd0);
    chk("late_done_no_start", 64'(starts_n - s0), 64'd0);
    chk("dflt_err", 64'(err), 64'd0);

`ifdef MAGMA_SEQ_TIMEOUT_EN
    // watchdog: core never answers
    stub_en = 1'b0;
    load(256'hE, 32'h0BAD_F00D);
    o0 = ovalid_n;
    in_valid = 1'b1; in_data = 64'h9;
    cyc();
    in_valid = 1'b0;
    k = 1;
    while (!err && k < 300) begin cyc(); k++; end
    // TO full WAIT cycles (cycles 2..TO+1), err visible the cycle after
    chk("wd_err_cycle", 64'(k), 64'(TO + 2));
    chk("wd_err", 64'(err), 64'd1);
    chk("wd_idle", 64'(busy), 64'd0);
    chk("wd_no_out", 64'(ovalid_n - o0), 64'd0);
    chk("wd_ctr_kept", core_data_in, 64'h0BAD_F00D_0000_0000);
    chk("wd_blk_cnt", 64'(blk_cnt), 64'd0);
    cyc();
    chk("wd_err_sticky", 64'(err), 64'd1);
    load(256'hE, 32'h0BAD_F00D);
    chk("wd_err_clear", 64'(err), 64'd0);
    stub_en = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
